// File: rtl/text_tile_if.sv
// Pixel-stream bundle between the sync generator, tile renderer and external font ROM.
// master = driving side (sync generator / host / ROM), slave = renderer.
interface text_tile_if #(
  parameter int AW = 12
);
  logic [9:0]    pixel_x;
  logic [9:0]    pixel_y;
  logic          video_on;
  logic          frame_tick;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          cursor_en;
  logic [6:0]    cursor_col;
  logic [AW-1:0] cursor_row;
  logic [10:0]   font_addr;
  logic [7:0]    font_data;
  logic          pix_out;
  logic          pix_valid;

  modport master (
    output pixel_x, pixel_y, video_on, frame_tick, we, waddr, wdata,
           cursor_en, cursor_col, cursor_row, font_data,
    input  font_addr, pix_out, pix_valid
  );

  modport slave (
    input  pixel_x, pixel_y, video_on, frame_tick, we, waddr, wdata,
           cursor_en, cursor_col, cursor_row, font_data,
    output font_addr, pix_out, pix_valid
  );
endinterface

// File: rtl/text_tile_renderer.sv
// Text-mode pixel generator: tile RAM -> external font ROM -> pixel, fixed 3-cycle latency,
// with inverse attribute and a blinking underline cursor.
module text_tile_renderer #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int FONT_H       = 16,
  parameter int BLINK_FRAMES = 30,
  parameter int AW           = $clog2(COLS*ROWS)
) (
  input  logic       clk,
  input  logic       reset,
  text_tile_if.slave bus
);

  localparam int DEPTH = COLS * ROWS;
  localparam int RB    = $clog2(FONT_H);
  localparam int FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [6:0]    col;
  logic [9:0]    row;
  logic [3:0]    glyph_row;
  logic [2:0]    bit_idx;
  logic          in_range;
  logic          cursor_hit;
  logic [AW-1:0] raddr;

  always_comb begin
    col        = bus.pixel_x[9:3];
    row        = bus.pixel_y >> RB;
    glyph_row  = 4'(bus.pixel_y[RB-1:0]);
    bit_idx    = ~bus.pixel_x[2:0];
    in_range   = (32'(col) < COLS) && (32'(row) < ROWS);
    raddr      = in_range ? AW'(32'(row) * COLS + 32'(col)) : '0;
    cursor_hit = bus.cursor_en && (col == bus.cursor_col) &&
                 (32'(row) == 32'(bus.cursor_row)) &&
                 (32'(glyph_row) >= FONT_H - 2);
  end

  logic [7:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (bus.we && (32'(bus.waddr) < DEPTH))
      ram[bus.waddr] <= bus.wdata;
  end

  // Stage 1: tile read (read-first against the write port) plus decoded sidebands
  logic [7:0] tile_p1;
  logic [3:0] glyph_row_p1;
  logic [2:0] bit_idx_p1;
  logic       in_range_p1;
  logic       cursor_p1;
  logic       vld_p1;

  always_ff @(posedge clk) begin
    if (reset) tile_p1 <= '0;
    else       tile_p1 <= ram[raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      glyph_row_p1 <= '0;
      bit_idx_p1   <= '0;
      in_range_p1  <= 1'b0;
      cursor_p1    <= 1'b0;
      vld_p1       <= 1'b0;
    end else begin
      glyph_row_p1 <= glyph_row;
      bit_idx_p1   <= bit_idx;
      in_range_p1  <= in_range;
      cursor_p1    <= cursor_hit;
      vld_p1       <= bus.video_on;
    end
  end

  // Stage 2: font ROM is addressed here and registers it externally
  assign bus.font_addr = {tile_p1[6:0], glyph_row_p1};

  logic [2:0] bit_idx_p2;
  logic       in_range_p2;
  logic       cursor_p2;
  logic       inv_p2;
  logic       vld_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx_p2  <= '0;
      in_range_p2 <= 1'b0;
      cursor_p2   <= 1'b0;
      inv_p2      <= 1'b0;
      vld_p2      <= 1'b0;
    end else begin
      bit_idx_p2  <= bit_idx_p1;
      in_range_p2 <= in_range_p1;
      cursor_p2   <= cursor_p1;
      inv_p2      <= tile_p1[7];
      vld_p2      <= vld_p1;
    end
  end

  // Blink timebase; phase is consumed directly by stage 3
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (bus.frame_tick) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Stage 3: glyph bit select, inverse, cursor overlay, blanking
  logic glyph_bit;
  logic pix_sel;

  always_comb begin
    glyph_bit = bus.font_data[bit_idx_p2] ^ inv_p2;
    pix_sel   = (cursor_p2 && blink_phase) ? 1'b1 : glyph_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pix_out   <= 1'b0;
      bus.pix_valid <= 1'b0;
    end else begin
      bus.pix_out   <= vld_p2 && in_range_p2 && pix_sel;
      bus.pix_valid <= vld_p2;
    end
  end

endmodule

// File: tb/tb_text_tile_renderer.sv
// Bench for text_tile_renderer: directed literal scans plus randomized traffic against
// a per-pixel behavioural model of the renderer.
module tb_text_tile_renderer;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int FH   = 16;
  localparam int BF   = 30;
  localparam int AW   = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  text_tile_if #(.AW(AW)) bus();

  text_tile_renderer #(
    .COLS(COLS), .ROWS(ROWS), .FONT_H(FH), .BLINK_FRAMES(BF), .AW(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // External synchronous-read font ROM
  logic [7:0] rom [2048];
  always @(posedge clk) bus.font_data <= rom[bus.font_addr];

  typedef struct packed {
    logic        vo;
    logic        inr;
    logic        hit;
    logic        g;
    logic [10:0] fa;
  } ent_t;

  logic [7:0]  mram [COLS*ROWS];
  ent_t        s1, s2;
  int          ticks = 0;
  logic        exp_pix, exp_vld, fa_known;
  logic [10:0] exp_fa;
  logic        started = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // What one input pixel must turn into, apart from the blink phase applied at output time
  function automatic ent_t predict(input int px, input int py, input logic vo,
                                   input logic cen, input int ccol, input int crow);
    ent_t e;
    logic [7:0] t;
    logic [7:0] f;
    int col, row, gr, bi;
    col = px / 8;
    row = py / FH;
    gr  = py % FH;
    bi  = 7 - (px % 8);
    e = '0;
    e.vo  = vo;
    e.inr = (col < COLS) && (row < ROWS);
    t = e.inr ? mram[row*COLS + col] : 8'h00;
    e.fa  = {t[6:0], 4'(gr)};
    f = rom[e.fa];
    e.g   = f[bi] ^ t[7];
    e.hit = cen && (col == ccol) && (row == crow) && (gr >= FH - 2);
    return e;
  endfunction

  initial begin
    forever begin
      ent_t n;
      logic ph;
      @(posedge clk);
      ph = ((ticks / BF) % 2) == 1;
      n = predict(int'(bus.pixel_x), int'(bus.pixel_y), bus.video_on,
                  bus.cursor_en, int'(bus.cursor_col), int'(bus.cursor_row));
      fa_known = 1'b0;
      if (reset) begin
        exp_pix  = 1'b0;
        exp_vld  = 1'b0;
        fa_known = 1'b1;
        exp_fa   = '0;
        s1       = '0;
        s2       = '0;
        ticks    = 0;
      end else begin
        exp_vld = s2.vo;
        exp_pix = s2.vo && s2.inr && ((s2.hit && ph) ? 1'b1 : s2.g);
        s2 = s1;
        s1 = n;
        if (n.inr) begin
          fa_known = 1'b1;
          exp_fa   = n.fa;
        end
        if (bus.frame_tick) ticks++;
      end
      if (bus.we && (int'(bus.waddr) < COLS*ROWS)) mram[bus.waddr] = bus.wdata;
      started = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("pixel", {bus.pix_out, bus.pix_valid}, {exp_pix, exp_vld});
        if (fa_known) chk("font_addr", bus.font_addr, exp_fa);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    bus.we    = 1'b1;
    bus.waddr = AW'(a);
    bus.wdata = 8'(d);
    cyc();
    bus.we = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      cyc();
      bus.frame_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic scan8(input string name, input int y, input int x0, input logic [7:0] expb);
    logic [7:0] got, gv;
    got = '0;
    gv  = '0;
    for (int j = 0; j < 10; j++) begin
      bus.pixel_x  = (j < 8) ? 10'(x0 + j) : 10'd1023;
      bus.pixel_y  = 10'(y);
      bus.video_on = (j < 8);
      cyc();
      if (j >= 2) begin
        got[9-j] = bus.pix_out;
        gv[9-j]  = bus.pix_valid;
      end
    end
    chk({name, " pix"}, got, expb);
    chk({name, " vld"}, gv, 8'hFF);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    rom[11'h413] = 8'b00011000;
    rom[11'h41D] = 8'b01100110;
    rom[11'h41E] = 8'b10000001;
    rom[11'h41F] = 8'b00111100;

    reset          = 1'b1;
    bus.pixel_x    = 10'd1023;
    bus.pixel_y    = 10'd0;
    bus.video_on   = 1'b0;
    bus.frame_tick = 1'b0;
    bus.we         = 1'b0;
    bus.waddr      = '0;
    bus.wdata      = '0;
    bus.cursor_en  = 1'b0;
    bus.cursor_col = '0;
    bus.cursor_row = '0;
    repeat (3) cyc();
    chk("reset pix_out", bus.pix_out, 0);
    chk("reset pix_valid", bus.pix_valid, 0);
    chk("reset font_addr", bus.font_addr, 0);
    reset = 1'b0;

    for (int a = 0; a < COLS*ROWS; a++) wr(a, int'($urandom_range(0, 255)));
    wr(0, 8'h41);
    wr(1, 8'hC1);
    wr(5, 8'h33);

    scan8("glyph A", 3, 0, 8'b00011000);
    scan8("inverse A", 3, 8, 8'b11100111);

    bus.cursor_en  = 1'b1;
    bus.cursor_col = 7'd0;
    bus.cursor_row = '0;
    scan8("cursor phase0", 14, 0, 8'b10000001);
    tick_n(30);
    scan8("cursor row14 on", 14, 0, 8'hFF);
    scan8("cursor row15 on", 15, 0, 8'hFF);
    scan8("cursor row13", 13, 0, 8'b01100110);
    tick_n(30);
    scan8("cursor row14 off", 14, 0, 8'b10000001);
    scan8("cursor row15 off", 15, 0, 8'b00111100);

    scan8("col 80 blank", 3, 640, 8'h00);
    wr(2400, 8'hFF);
    scan8("after oob write", 3, 0, 8'b00011000);

    bus.pixel_x  = 10'd40;
    bus.pixel_y  = 10'd3;
    bus.video_on = 1'b1;
    bus.we       = 1'b1;
    bus.waddr    = AW'(5);
    bus.wdata    = 8'h42;
    cyc();
    chk("read-first old code", bus.font_addr, 11'h333);
    bus.we = 1'b0;
    cyc();
    chk("read after write", bus.font_addr, 11'h423);

    tick_n(30);
    bus.pixel_x  = 10'd0;
    bus.pixel_y  = 10'd3;
    bus.video_on = 1'b1;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("mid-scan reset out", {bus.pix_out, bus.pix_valid}, 0);
      cyc();
    end
    chk("first pixel after reset", {bus.pix_out, bus.pix_valid}, 2'b01);
    scan8("blink cleared by reset", 14, 0, 8'b10000001);

    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 499) == 0);
      bus.frame_tick = ($urandom_range(0, 3) == 0);
      bus.we         = ($urandom_range(0, 7) == 0);
      bus.waddr      = AW'($urandom_range(0, 2500));
      bus.wdata      = 8'($urandom);
      bus.video_on   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) begin
        bus.cursor_en  = 1'($urandom);
        bus.cursor_col = 7'($urandom_range(0, 85));
        bus.cursor_row = AW'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.pixel_x = {bus.cursor_col, 3'($urandom)};
        bus.pixel_y = 10'(int'(bus.cursor_row) * FH + int'($urandom_range(12, 15)));
      end else begin
        bus.pixel_x = 10'($urandom);
        bus.pixel_y = 10'($urandom_range(0, 520));
      end
      cyc();
    end
    reset = 1'b0;
    bus.we = 1'b0;
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
